bus_sequencer: RTL

//  Parametrised successor to the fixed 16-slot bus timing: divides clk16 into a repeating bus cycle of

---
 rtl/bus_seq_pkg.sv | 32 +++
 rtl/bus_sequencer_dma_arbiter.sv | 63 ++++++
 rtl/bus_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/bus_seq_pkg.sv
// Shared types and helpers for the bus sequencer: slot kinds, sizing helpers
// and the round-robin picker used by the DMA arbiter.
package bus_seq_pkg;

  localparam int MAX_REQ = 16;
  localparam int REQ_W   = $clog2(MAX_REQ);

  typedef enum logic [1:0] {SLOT_VIDEO, SLOT_DMA, SLOT_CPU} slot_e;

  function automatic int cpu_len(input int cycle_len, input int video_len, input int dma_len);
    return cycle_len - video_len - dma_len;
  endfunction

  function automatic int cnt_w(input int cycle_len);
    return (cycle_len > 1) ? $clog2(cycle_len) : 1;
  endfunction

  // First eligible index at or after rr_ptr, wrapping at num_req; one-hot, zero if none.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] eligible,
                                                 input int rr_ptr, input int num_req);
    logic [MAX_REQ-1:0] pick;
    int idx;
    pick = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = rr_ptr + k;
      if (idx >= num_req) idx = idx - num_req;
      if (k < num_req && pick == '0 && eligible[REQ_W'(idx)]) pick[REQ_W'(idx)] = 1'b1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/bus_sequencer_dma_arbiter.sv
// DMA requester front end: request synchronisers, round-robin slot arbitration
// and the grant/ack registers of the 4-phase handshake.
module dma_arbiter
  import bus_seq_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk16,
  input  logic               res_b,
  input  logic [NUM_REQ-1:0] dma_req,
  input  logic               slot_start,
  input  logic               slot_end,
  output logic [NUM_REQ-1:0] dma_grant,
  output logic [NUM_REQ-1:0] grant_next,
  output logic [NUM_REQ-1:0] dma_ack
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] sync_q, req_s_q, grant_q, grant_d, ack_q, ack_d, eligible;
  logic [MAX_REQ-1:0] pick;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    // The current owner is excluded so a back-to-back slot cannot go to it before its ack.
    eligible = req_s_q & ~ack_q & ~grant_q;
    pick     = rr_pick(MAX_REQ'(eligible), int'(rr_ptr_q), NUM_REQ);
    if (slot_start) begin
      grant_d = pick[NUM_REQ-1:0];
      for (int i = 0; i < NUM_REQ; i++)
        if (pick[i]) rr_ptr_d = PTR_W'((i + 1) % NUM_REQ);
    end else if (slot_end) begin
      grant_d = '0;
    end
    for (int i = 0; i < NUM_REQ; i++)
      ack_d[i] = ack_q[i] ? req_s_q[i] : (slot_end & grant_q[i]);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk16 or negedge res_b) begin
    if (!res_b) begin
      sync_q   <= '0;
      req_s_q  <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      sync_q   <= dma_req;
      req_s_q  <= sync_q;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign dma_grant  = grant_q;
  assign grant_next = grant_d;
  assign dma_ack    = ack_q;

endmodule

// File: rtl/bus_sequencer.sv
// Bus cycle sequencer: divides clk16 into video, DMA and CPU slots and drives the
// registered slot selects and strobes; DMA ownership comes from dma_arbiter.
module bus_sequencer
  import bus_seq_pkg::*;
#(
  parameter int CYCLE_LEN  = 16,
  parameter int VIDEO_LEN  = 4,
  parameter int DMA_LEN    = 4,
  parameter int DMA_STROBE = 2,
  parameter int NUM_REQ    = 2
) (
  input  logic               clk16,
  input  logic               res_b,
  input  logic               cpu_halt,
  input  logic [NUM_REQ-1:0] dma_req,
  output logic [NUM_REQ-1:0] dma_ack,
  output logic [NUM_REQ-1:0] dma_grant,
  output logic               dma_select,
  output logic               dma_strobe,
  output logic               video_select,
  output logic               video_ram_strobe,
  output logic               video_rom_strobe,
  output logic               cpu_select,
  output logic               phi2,
  output logic               clk8,
  output logic               cycle_start
);

  localparam int CPU_LEN = cpu_len(CYCLE_LEN, VIDEO_LEN, DMA_LEN);
  localparam int CNT_W   = cnt_w(CYCLE_LEN);
  localparam int DMA_END = VIDEO_LEN + DMA_LEN;

  generate
    if (VIDEO_LEN < 2 || VIDEO_LEN % 2 != 0) begin : g_bad_video
      $error("bus_sequencer: VIDEO_LEN must be even and >= 2");
    end
    if (DMA_STROBE < 1 || DMA_STROBE > DMA_LEN) begin : g_bad_strobe
      $error("bus_sequencer: DMA_STROBE must be in 1..DMA_LEN");
    end
    if (CPU_LEN < 2 || CPU_LEN % 2 != 0 || CPU_LEN % DMA_LEN != 0) begin : g_bad_cpu
      $error("bus_sequencer: CPU_LEN must be >= 2, even and a multiple of DMA_LEN");
    end
    if (NUM_REQ < 1 || NUM_REQ > MAX_REQ) begin : g_bad_req
      $error("bus_sequencer: NUM_REQ out of range");
    end
  endgenerate

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               halt_q, halt_d;
  slot_e              slot_d;
  int                 cnt_i, nxt_i;
  logic               slot_start, slot_end;
  logic [NUM_REQ-1:0] grant_next;

  logic video_select_d, video_ram_strobe_d, video_rom_strobe_d, cpu_select_d;
  logic phi2_d, clk8_d, cycle_start_d, dma_select_d, dma_strobe_d;
  logic video_select_q, video_ram_strobe_q, video_rom_strobe_q, cpu_select_q;
  logic phi2_q, clk8_q, cycle_start_q, dma_select_q, dma_strobe_q;

  // Outputs are decoded from the next count so that each register shows the slot of its own clock.
  always_comb begin
    cnt_i  = int'(cnt_q);
    cnt_d  = (cnt_i == CYCLE_LEN - 1) ? '0 : cnt_q + CNT_W'(1);
    nxt_i  = int'(cnt_d);
    halt_d = (cnt_i == DMA_END - 1) ? cpu_halt : halt_q;

    if (nxt_i < VIDEO_LEN)                 slot_d = SLOT_VIDEO;
    else if (nxt_i < DMA_END || halt_d)    slot_d = SLOT_DMA;
    else                                   slot_d = SLOT_CPU;

    slot_start = (slot_d == SLOT_DMA) && ((nxt_i - VIDEO_LEN) % DMA_LEN == 0);
    slot_end   = (cnt_i >= VIDEO_LEN) && ((cnt_i - VIDEO_LEN) % DMA_LEN == DMA_LEN - 1) &&
                 (cnt_i < DMA_END || halt_q);

    video_select_d     = (slot_d == SLOT_VIDEO);
    video_ram_strobe_d = (nxt_i == VIDEO_LEN / 2 - 1);
    video_rom_strobe_d = (nxt_i == VIDEO_LEN - 1);
    cpu_select_d       = (slot_d == SLOT_CPU);
    phi2_d             = (nxt_i >= CYCLE_LEN - CPU_LEN / 2);
    clk8_d             = ~cnt_d[0];
    cycle_start_d      = (nxt_i == 0);
    dma_select_d       = |grant_next;
    dma_strobe_d       = dma_select_d && ((nxt_i - VIDEO_LEN) % DMA_LEN >= DMA_LEN - DMA_STROBE);
  end

  always_ff @(posedge clk16 or negedge res_b) begin
    if (!res_b) begin
      cnt_q              <= CNT_W'(CYCLE_LEN - 1);
      halt_q             <= 1'b0;
      video_select_q     <= 1'b0;
      video_ram_strobe_q <= 1'b0;
      video_rom_strobe_q <= 1'b0;
      cpu_select_q       <= 1'b0;
      phi2_q             <= 1'b0;
      clk8_q             <= 1'b0;
      cycle_start_q      <= 1'b0;
      dma_select_q       <= 1'b0;
      dma_strobe_q       <= 1'b0;
    end else begin
      cnt_q              <= cnt_d;
      halt_q             <= halt_d;
      video_select_q     <= video_select_d;
      video_ram_strobe_q <= video_ram_strobe_d;
      video_rom_strobe_q <= video_rom_strobe_d;
      cpu_select_q       <= cpu_select_d;
      phi2_q             <= phi2_d;
      clk8_q             <= clk8_d;
      cycle_start_q      <= cycle_start_d;
      dma_select_q       <= dma_select_d;
      dma_strobe_q       <= dma_strobe_d;
    end
  end

  dma_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk16      (clk16),
    .res_b      (res_b),
    .dma_req    (dma_req),
    .slot_start (slot_start),
    .slot_end   (slot_end),
    .dma_grant  (dma_grant),
    .grant_next (grant_next),
    .dma_ack    (dma_ack)
  );

  assign video_select     = video_select_q;
  assign video_ram_strobe = video_ram_strobe_q;
  assign video_rom_strobe = video_rom_strobe_q;
  assign cpu_select       = cpu_select_q;
  assign phi2             = phi2_q;
  assign clk8             = clk8_q;
  assign cycle_start      = cycle_start_q;
  assign dma_select       = dma_select_q;
  assign dma_strobe       = dma_strobe_q;

endmodule
